// File: rtl/multi_channel_interval_timer.sv
// rtl/multi_channel_interval_timer.sv - multi-channel Avalon-MM interval timer
//
// NUM_CH independent down-counters, each with a prescaler, one-shot or
// continuous mode, snapshot register and interrupt enable.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   address    word address: [AW-1:3] channel, [2:0] register offset
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data (1-cycle latency, independent of chipselect)
//   irq        OR of all enabled pending timeouts
//   irq_mask   per-channel interrupt (TO & ITO)
//
// Register offsets per channel:
//   0 STATUS    bit0 TO, bit1 RUN (ro); any write clears TO
//   1 CONTROL   bit0 ITO, bit1 CONT; bit2 START, bit3 STOP strobes (read 0)
//   2 PERIOD_LO period[31:0]
//   3 PERIOD_HI period[CNT_W-1:32]
//   4/5 SNAP_LO/HI  write captures counter, read returns snapshot
//   6 PRESCALE  counter steps once every PRESCALE+1 clocks
//   7 PENDING   TO bits of all channels
module multi_channel_interval_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter int          PRE_W          = 16,
    parameter logic [63:0] DEFAULT_PERIOD = 64'd499999,
    localparam int         AW             = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_mask
);

    // Channel field is empty for a single-channel build; keep one bit tied to 0.
    localparam int CW = (AW > 3) ? AW - 3 : 1;

    logic [CW-1:0]     ch_idx;
    logic [2:0]        reg_off;
    logic              ch_ok;
    logic              wr;
    logic [NUM_CH-1:0] to_vec;
    logic [NUM_CH-1:0] ito_vec;
    logic [31:0]       rd_ch [NUM_CH];
    logic [31:0]       rd_next;

    assign ch_idx  = CW'(address >> 3);
    assign reg_off = address[2:0];
    assign ch_ok   = (32'(ch_idx) < NUM_CH);
    assign wr      = chipselect & ~write_n;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [CNT_W-1:0] period;
            logic [CNT_W-1:0] counter;
            logic [CNT_W-1:0] snap;
            logic [PRE_W-1:0] prescale;
            logic [PRE_W-1:0] pc;
            logic             ito;
            logic             cont;
            logic             run;
            logic             to_flag;
            logic             zero_q;
            logic             force_reload;
            logic             sel;
            logic             wr_status;
            logic             wr_ctrl;
            logic             wr_period;
            logic             wr_snap;
            logic             wr_pre;
            logic             start;
            logic             stop;
            logic             tick;
            logic             at_zero;
            logic             timeout_evt;
            logic [63:0]      period_ext;
            logic [63:0]      snap_ext;
            logic [63:0]      period_wr;
            logic [31:0]      rd_val;

            assign sel       = wr & ch_ok & (ch_idx == CW'(c));
            assign wr_status = sel & (reg_off == 3'd0);
            assign wr_ctrl   = sel & (reg_off == 3'd1);
            assign wr_period = sel & ((reg_off == 3'd2) | (reg_off == 3'd3));
            assign wr_snap   = sel & ((reg_off == 3'd4) | (reg_off == 3'd5));
            assign wr_pre    = sel & (reg_off == 3'd6);
            assign start     = wr_ctrl & writedata[2];
            assign stop      = wr_ctrl & writedata[3];

            assign tick        = run & (pc == prescale);
            assign at_zero     = (counter == '0);
            // Fires on entry into zero only, so a zero period in continuous
            // mode raises one timeout rather than one per tick.
            assign timeout_evt = at_zero & ~zero_q;

            assign period_ext = 64'(period);
            assign snap_ext   = 64'(snap);

            // Merge the written half into the current period; bits above
            // CNT_W fall away in the truncation below.
            always_comb begin
                period_wr = period_ext;
                if (reg_off == 3'd3) begin
                    period_wr[63:32] = writedata;
                end else begin
                    period_wr[31:0] = writedata;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    period       <= CNT_W'(DEFAULT_PERIOD);
                    counter      <= CNT_W'(DEFAULT_PERIOD);
                    snap         <= '0;
                    prescale     <= '0;
                    pc           <= '0;
                    ito          <= 1'b0;
                    cont         <= 1'b0;
                    run          <= 1'b0;
                    to_flag      <= 1'b0;
                    zero_q       <= 1'b0;
                    force_reload <= 1'b0;
                end else begin
                    force_reload <= wr_period;
                    zero_q       <= at_zero;

                    if (wr_period) begin
                        period <= CNT_W'(period_wr);
                    end
                    if (wr_pre) begin
                        prescale <= writedata[PRE_W-1:0];
                    end
                    if (wr_ctrl) begin
                        ito  <= writedata[0];
                        cont <= writedata[1];
                    end
                    if (wr_snap) begin
                        snap <= counter;
                    end

                    // A timeout arriving with a STATUS write must not be lost.
                    if (timeout_evt) begin
                        to_flag <= 1'b1;
                    end else if (wr_status) begin
                        to_flag <= 1'b0;
                    end

                    if (start | wr_period | wr_pre) begin
                        pc <= '0;
                    end else if (run) begin
                        pc <= tick ? '0 : pc + 1'b1;
                    end

                    // One-shot channels park at zero; only continuous mode reloads.
                    if (force_reload) begin
                        counter <= period;
                    end else if (tick) begin
                        if (at_zero) begin
                            if (cont) begin
                                counter <= period;
                            end
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end

                    if (start) begin
                        run <= 1'b1;
                    end else if (stop | force_reload | (at_zero & tick & ~cont)) begin
                        run <= 1'b0;
                    end
                end
            end

            always_comb begin
                rd_val = 32'd0;
                case (reg_off)
                    3'd0:    rd_val = {30'd0, run, to_flag};
                    3'd1:    rd_val = {30'd0, cont, ito};
                    3'd2:    rd_val = period_ext[31:0];
                    3'd3:    rd_val = period_ext[63:32];
                    3'd4:    rd_val = snap_ext[31:0];
                    3'd5:    rd_val = snap_ext[63:32];
                    3'd6:    rd_val = 32'(prescale);
                    default: rd_val = 32'd0;
                endcase
            end

            assign rd_ch[c]   = rd_val;
            assign to_vec[c]  = to_flag;
            assign ito_vec[c] = ito;
        end
    endgenerate

    always_comb begin
        rd_next = 32'd0;
        if (ch_ok) begin
            if (reg_off == 3'd7) begin
                rd_next = 32'(to_vec);
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_idx == CW'(i)) begin
                        rd_next = rd_ch[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 32'd0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq_mask = to_vec & ito_vec;
    assign irq      = |irq_mask;

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// tb/tb_multi_channel_interval_timer.sv - directed scoreboard bench for multi_channel_interval_timer
module tb_multi_channel_interval_timer;

    logic        clk;
    logic        reset;
    logic [5:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [4:0]  irq_mask;

    int total  = 0;
    int passed = 0;

    logic [63:0] exp_q [$];
    string       tag_q [$];

    multi_channel_interval_timer #(
        .NUM_CH(5),
        .CNT_W(48),
        .PRE_W(16),
        .DEFAULT_PERIOD(64'd499999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .irq_mask(irq_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ad(input int ch, input int off);
        return 6'((ch << 3) | off);
    endfunction

    task automatic check(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (obs === e) begin
            passed++;
        end else begin
            $display("FAIL %s observed=%0h expected=%0h", t, obs, e);
            $error("check %s", t);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        check(obs);
    endtask

    // All bus tasks are entered just after a negedge and return at the next one.
    task automatic wr(input int ch, input int off, input logic [31:0] d);
        address    = ad(ch, off);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input int ch, input int off, input logic [31:0] exp, input string tag);
        address    = ad(ch, off);
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(64'(exp));
        tag_q.push_back(tag);
        @(negedge clk);
        chipselect = 1'b0;
        check(64'(readdata));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        idle(3);
        chk("rst_readdata", 64'(readdata), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_irq_mask", 64'(irq_mask), 64'd0);
        reset = 1'b0;

        // Reset values
        rd(0, 2, 32'd499999, "ch0_period_lo_default");
        rd(0, 3, 32'd0, "ch0_period_hi_default");
        rd(0, 0, 32'd0, "ch0_status_default");
        chk("irq_after_reset", 64'(irq), 64'd0);

        // Ch1 continuous, period 5, prescale 0
        wr(1, 2, 32'd5);
        wr(1, 6, 32'd0);
        wr(1, 1, 32'h7);
        wr(1, 4, 32'd0);
        rd(1, 4, 32'd5, "ch1_snap_5");
        wr(1, 4, 32'd0);
        rd(1, 4, 32'd3, "ch1_snap_3");
        chk("ch1_irq_before_zero", 64'(irq), 64'd0);
        wr(1, 4, 32'd0);
        chk("ch1_irq_at_zero_cycle", 64'(irq), 64'd0);
        rd(1, 4, 32'd1, "ch1_snap_1");
        chk("ch1_irq_set", 64'(irq), 64'd1);
        chk("ch1_irq_mask", 64'(irq_mask), 64'h2);
        wr(1, 4, 32'd0);
        rd(1, 4, 32'd5, "ch1_snap_reload_5");
        rd(0, 7, 32'h2, "pending_ch1");
        rd(1, 0, 32'h3, "ch1_status_to_run");
        wr(1, 0, 32'd0);
        chk("ch1_irq_cleared", 64'(irq), 64'd0);
        idle(1);
        chk("ch1_irq_second_timeout", 64'(irq), 64'd1);
        idle(1);
        wr(1, 0, 32'd0);
        chk("ch1_irq_cleared_again", 64'(irq), 64'd0);
        idle(3);
        chk("ch1_irq_before_simul", 64'(irq), 64'd0);
        wr(1, 0, 32'd0);
        chk("ch1_set_wins_over_clear", 64'(irq), 64'd1);
        wr(1, 1, 32'h8);
        wr(1, 0, 32'd0);
        chk("ch1_quiet", 64'(irq_mask), 64'd0);

        // Ch2 one-shot, period 3, prescale 2
        wr(2, 2, 32'd3);
        wr(2, 6, 32'd2);
        wr(2, 1, 32'h5);
        idle(9);
        chk("ch2_no_to_before_zero", 64'(irq_mask), 64'd0);
        idle(1);
        chk("ch2_to_after_9_clocks", 64'(irq_mask), 64'h4);
        idle(3);
        rd(2, 0, 32'h1, "ch2_status_stopped");
        wr(2, 0, 32'd0);
        idle(20);
        chk("ch2_single_event", 64'(irq_mask), 64'd0);
        wr(2, 4, 32'd0);
        rd(2, 4, 32'd0, "ch2_counter_stays_0");
        rd(2, 1, 32'h1, "ch2_control_readback");

        // Ch0 simultaneous START/STOP, reload while running
        wr(0, 1, 32'hC);
        rd(0, 0, 32'h2, "ch0_start_wins");
        wr(0, 2, 32'd100);
        rd(0, 0, 32'h2, "ch0_run_one_after_write");
        rd(0, 0, 32'h0, "ch0_run_cleared_two_after");
        wr(0, 4, 32'd0);
        rd(0, 4, 32'd100, "ch0_counter_new_period");
        wr(0, 2, 32'd50);
        wr(0, 1, 32'h4);
        rd(0, 0, 32'h2, "ch0_start_with_reload");
        wr(0, 1, 32'h8);

        // Ch3 48-bit snapshot
        wr(3, 3, 32'h1);
        wr(3, 2, 32'h10);
        wr(3, 1, 32'h4);
        idle(2);
        wr(3, 4, 32'd0);
        rd(3, 5, 32'h1, "ch3_snap_hi");
        rd(3, 4, 32'hE, "ch3_snap_lo");
        wr(3, 3, 32'hFFFF_FFFF);
        rd(3, 3, 32'h0000_FFFF, "ch3_period_hi_mask");

        // Out-of-range channel
        wr(5, 2, 32'h1234);
        rd(5, 2, 32'd0, "ch5_read_zero");
        rd(1, 2, 32'd5, "ch1_period_untouched");

        // Reset mid-count
        wr(1, 1, 32'h7);
        idle(10);
        chk("pre_reset_irq", 64'(irq), 64'd1);
        address = ad(0, 2);
        idle(1);
        chk("pre_reset_readdata", 64'(readdata), 64'd50);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_readdata", 64'(readdata), 64'd0);
        chk("async_reset_irq", 64'(irq), 64'd0);
        chk("async_reset_irq_mask", 64'(irq_mask), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(0, 2, 32'd499999, "post_reset_period");
        wr(0, 4, 32'd0);
        rd(0, 4, 32'd499999, "post_reset_counter");
        rd(0, 0, 32'd0, "post_reset_status");
        rd(1, 1, 32'd0, "post_reset_control");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
